mcycle_ctrl_fsm: RTL and testbench

Main control state machine for the multicycle MIPS datapath. Decodes the instruction-register opcode and steps the shared ALU, memory port, IR, PC and register file through fetch, decode, execute, memory and writeback. It drives `oALUOp` into the ALU control unit, which combines it with `funct` to select the ALU operation. It also stalls on a single-port memory ready handshake and counts retired instructions.

---
 rtl/mcycle_ctrl_fsm_if.sv | 33 +++
 rtl/mcycle_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_mcycle_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_ctrl_fsm_if.sv
// Datapath control bundle for the multicycle MIPS control FSM.
// master: FSM side (reads opcode/ready, drives controls); slave: datapath side.
interface mcycle_ctrl_fsm_if;
    logic [5:0] iOp;
    logic       iMemReady;
    logic       oPCWrite;
    logic       oPCWriteCond;
    logic       oIorD;
    logic       oMemRead;
    logic       oMemWrite;
    logic       oMemtoReg;
    logic       oIRWrite;
    logic       oALUSrcA;
    logic       oRegWrite;
    logic       oRegDst;
    logic [1:0] oPCSource;
    logic [1:0] oALUOp;
    logic [1:0] oALUSrcB;

    modport master (
        input  iOp, iMemReady,
        output oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite,
        output oMemtoReg, oIRWrite, oALUSrcA, oRegWrite, oRegDst,
        output oPCSource, oALUOp, oALUSrcB
    );

    modport slave (
        output iOp, iMemReady,
        input  oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite,
        input  oMemtoReg, oIRWrite, oALUSrcA, oRegWrite, oRegDst,
        input  oPCSource, oALUOp, oALUSrcB
    );
endinterface

// File: rtl/mcycle_ctrl_fsm.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/mem/writeback sequencing.
// Ports: iclk, irst_n (async low), bus (opcode, mem ready, controls), oState, oIllegal, oRetired.
module mcycle_ctrl_fsm #(
    parameter int RETIRE_W = 16
) (
    input  logic                iclk,
    input  logic                irst_n,
    mcycle_ctrl_fsm_if.master   bus,
    output logic [3:0]          oState,
    output logic                oIllegal,
    output logic [RETIRE_W-1:0] oRetired
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t              r_state;
    state_t              w_next;
    logic                w_retire;
    logic                w_illegal;
    logic [RETIRE_W-1:0] r_retired;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state   <= FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        unique case (r_state)
            FETCH:  if (bus.iMemReady) w_next = DECODE;
            DECODE: begin
                unique case (bus.iOp)
                    OP_R:         w_next = EXEC;
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_BEQ:       w_next = BRANCH;
                    OP_J:         w_next = JUMP;
                    OP_ADDI:      w_next = ADDIEX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            MEMADR: w_next = (bus.iOp == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.iMemReady) w_next = MEMWB;
            MEMWR: begin
                if (bus.iMemReady) begin
                    w_next   = FETCH;
                    w_retire = 1'b1;
                end
            end
            EXEC:   w_next = ALUWB;
            ADDIEX: w_next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
                w_next   = FETCH;
                w_retire = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    // Reset gates every control, including the FETCH read that
    // the reset state would otherwise decode to.
    always_comb begin
        bus.oPCWrite     = 1'b0;
        bus.oPCWriteCond = 1'b0;
        bus.oIorD        = 1'b0;
        bus.oMemRead     = 1'b0;
        bus.oMemWrite    = 1'b0;
        bus.oMemtoReg    = 1'b0;
        bus.oIRWrite     = 1'b0;
        bus.oALUSrcA     = 1'b0;
        bus.oRegWrite    = 1'b0;
        bus.oRegDst      = 1'b0;
        bus.oPCSource    = 2'b00;
        bus.oALUOp       = 2'b00;
        bus.oALUSrcB     = 2'b00;
        if (irst_n) begin
            unique case (r_state)
                FETCH: begin
                    bus.oMemRead = 1'b1;
                    bus.oALUSrcB = 2'b01;
                    bus.oIRWrite = bus.iMemReady;
                    bus.oPCWrite = bus.iMemReady;
                end
                DECODE: bus.oALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    bus.oALUSrcA = 1'b1;
                    bus.oALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.oMemRead = 1'b1;
                    bus.oIorD    = 1'b1;
                end
                MEMWR: begin
                    bus.oMemWrite = 1'b1;
                    bus.oIorD     = 1'b1;
                end
                MEMWB: begin
                    bus.oMemtoReg = 1'b1;
                    bus.oRegWrite = 1'b1;
                end
                EXEC: begin
                    bus.oALUSrcA = 1'b1;
                    bus.oALUOp   = 2'b10;
                end
                ALUWB: begin
                    bus.oRegDst   = 1'b1;
                    bus.oRegWrite = 1'b1;
                end
                ADDIWB: bus.oRegWrite = 1'b1;
                BRANCH: begin
                    bus.oALUSrcA     = 1'b1;
                    bus.oALUOp       = 2'b01;
                    bus.oPCWriteCond = 1'b1;
                    bus.oPCSource    = 2'b01;
                end
                JUMP: begin
                    bus.oPCWrite  = 1'b1;
                    bus.oPCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign oState   = r_state;
    assign oIllegal = w_illegal & irst_n;
    assign oRetired = r_retired;
endmodule

// File: tb/tb_mcycle_ctrl_fsm.sv
// Self-checking bench for mcycle_ctrl_fsm with a path-table reference model.
// Random instruction mix, random stalls, reset, wrap and async abort scenarios.
module tb_mcycle_ctrl_fsm;
    localparam int W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct {
        int st;
        bit care;
        bit rdy;
    } ent_t;

    logic         iclk   = 1'b0;
    logic         irst_n = 1'b1;
    logic [3:0]   oState;
    logic         oIllegal;
    logic [W-1:0] oRetired;
    logic [15:0]  w_act;

    int ntests    = 0;
    int nfail     = 0;
    int model_ret = 0;

    mcycle_ctrl_fsm_if bus ();

    mcycle_ctrl_fsm #(.RETIRE_W(W)) dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .bus      (bus),
        .oState   (oState),
        .oIllegal (oIllegal),
        .oRetired (oRetired)
    );

    always #5 iclk = ~iclk;

    assign w_act = {bus.oPCWrite, bus.oPCWriteCond, bus.oIorD,
                    bus.oMemRead, bus.oMemWrite, bus.oMemtoReg,
                    bus.oIRWrite, bus.oALUSrcA, bus.oRegWrite,
                    bus.oRegDst, bus.oPCSource, bus.oALUOp,
                    bus.oALUSrcB};

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    // Control table by state number, same bit order as w_act.
    function automatic logic [15:0] exp_ctrl(input int st, input bit r);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0: begin mr = 1; asb = 2'b01; irw = r; pcw = r; end
            1: asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3: begin mr = 1; iord = 1; end
            4: begin m2r = 1; rw = 1; end
            5: begin mw = 1; iord = 1; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rd = 1; rw = 1; end
            8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9: begin pcw = 1; pcs = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, aop, asb};
    endfunction

    // Entered just after a rising edge with the DUT in FETCH;
    // leaves just after the edge that returns it to FETCH.
    task automatic run_instr(input logic [5:0] op, input int fs,
                             input int ms, input string nm);
        ent_t q[$];
        bit legal;
        bit r;
        logic [5:0] opd;
        legal = is_legal(op);
        for (int i = 0; i < fs; i++) q.push_back('{0, 1'b1, 1'b0});
        q.push_back('{0, 1'b1, 1'b1});
        q.push_back('{1, 1'b0, 1'b0});
        case (op)
            OP_R:    begin q.push_back('{6, 1'b0, 1'b0}); q.push_back('{7, 1'b0, 1'b0}); end
            OP_LW: begin
                q.push_back('{2, 1'b0, 1'b0});
                for (int i = 0; i < ms; i++) q.push_back('{3, 1'b1, 1'b0});
                q.push_back('{3, 1'b1, 1'b1});
                q.push_back('{4, 1'b0, 1'b0});
            end
            OP_SW: begin
                q.push_back('{2, 1'b0, 1'b0});
                for (int i = 0; i < ms; i++) q.push_back('{5, 1'b1, 1'b0});
                q.push_back('{5, 1'b1, 1'b1});
            end
            OP_BEQ:  q.push_back('{8, 1'b0, 1'b0});
            OP_J:    q.push_back('{9, 1'b0, 1'b0});
            OP_ADDI: begin q.push_back('{10, 1'b0, 1'b0}); q.push_back('{11, 1'b0, 1'b0}); end
            default: ;
        endcase
        foreach (q[i]) begin
            r   = q[i].care ? q[i].rdy : 1'($urandom);
            opd = (q[i].st == 1 || q[i].st == 2) ? op : 6'($urandom);
            bus.iMemReady = r;
            bus.iOp       = opd;
            @(negedge iclk);
            ntests++;
            if (oState !== 4'(q[i].st)) begin
                nfail++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", nm, i, oState, q[i].st);
            end
            ntests++;
            if (w_act !== exp_ctrl(q[i].st, r)) begin
                nfail++;
                $display("FAIL %s ctrl cyc%0d: got %h want %h", nm, i, w_act, exp_ctrl(q[i].st, r));
            end
            ntests++;
            if (oIllegal !== (q[i].st == 1 && !legal)) begin
                nfail++;
                $display("FAIL %s illegal cyc%0d: got %b want %b", nm, i, oIllegal, (q[i].st == 1 && !legal));
            end
            @(posedge iclk);
            #1;
        end
        if (legal) model_ret = (model_ret + 1) % (1 << W);
        ntests++;
        if (oState !== 4'd0) begin
            nfail++;
            $display("FAIL %s end state: got %0d want 0", nm, oState);
        end
        ntests++;
        if (oRetired !== W'(model_ret)) begin
            nfail++;
            $display("FAIL %s retired: got %0d want %0d", nm, oRetired, model_ret);
        end
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        irst_n    = 1'b1;
        model_ret = 0;
    endtask

    task automatic test_reset();
        bus.iMemReady = 1'b1;
        bus.iOp       = OP_J;
        irst_n        = 1'b0;
        repeat (3) begin
            @(negedge iclk);
            ntests++;
            if (w_act !== 16'h0 || oIllegal !== 1'b0) begin
                nfail++;
                $display("FAIL reset ctrl: got %h/%b want 0", w_act, oIllegal);
            end
            ntests++;
            if (oState !== 4'd0 || oRetired !== '0) begin
                nfail++;
                $display("FAIL reset state: got %0d/%0d want 0/0", oState, oRetired);
            end
        end
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        @(negedge iclk);
        ntests++;
        if ({bus.oMemRead, bus.oIRWrite, bus.oPCWrite} !== 3'b111) begin
            nfail++;
            $display("FAIL first_fetch: got %b want 111", {bus.oMemRead, bus.oIRWrite, bus.oPCWrite});
        end
        repeat (3) begin
            @(posedge iclk);
            #1;
        end
        model_ret = 1;
        ntests++;
        if (oState !== 4'd0 || oRetired !== W'(model_ret)) begin
            nfail++;
            $display("FAIL first_j: got %0d/%0d want 0/%0d", oState, oRetired, model_ret);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        run_instr(OP_R, 0, 0, "seq_r");
        run_instr(OP_LW, 0, 0, "seq_lw");
        run_instr(OP_SW, 0, 0, "seq_sw");
        run_instr(OP_BEQ, 0, 0, "seq_beq");
        run_instr(OP_J, 0, 0, "seq_j");
        ntests++;
        if (oRetired !== W'(5)) begin
            nfail++;
            $display("FAIL seq_total: got %0d want 5", oRetired);
        end
    endtask

    task automatic test_stall();
        run_instr(OP_LW, 3, 2, "stall_lw");
        run_instr(OP_SW, 1, 3, "stall_sw");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(6'b111111, 2, 0, "illegal2");
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (17) run_instr(OP_J, 0, 0, "wrap_j");
        ntests++;
        if (oRetired !== W'(1)) begin
            nfail++;
            $display("FAIL wrap: got %0d want 1", oRetired);
        end
    endtask

    task automatic test_async_reset();
        bus.iOp       = OP_LW;
        bus.iMemReady = 1'b1;
        repeat (3) begin
            @(posedge iclk);
            #1;
        end
        bus.iMemReady = 1'b0;
        @(negedge iclk);
        ntests++;
        if (oState !== 4'd3 || bus.oMemRead !== 1'b1 || bus.oIorD !== 1'b1) begin
            nfail++;
            $display("FAIL async_pre: got st%0d rd%b iord%b want 3/1/1", oState, bus.oMemRead, bus.oIorD);
        end
        #1;
        irst_n = 1'b0;
        #1;
        ntests++;
        if (bus.oMemRead !== 1'b0 || bus.oIorD !== 1'b0 || oState !== 4'd0) begin
            nfail++;
            $display("FAIL async_drop: got rd%b iord%b st%0d want 0/0/0", bus.oMemRead, bus.oIorD, oState);
        end
        @(posedge iclk);
        #1;
        irst_n        = 1'b1;
        bus.iMemReady = 1'b1;
        model_ret     = 0;
        #1;
        ntests++;
        if (oState !== 4'd0 || oRetired !== '0) begin
            nfail++;
            $display("FAIL async_post: got %0d/%0d want 0/0", oState, oRetired);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        bus.iOp       = 6'd0;
        bus.iMemReady = 1'b0;
        test_reset();
        test_sequence();
        test_stall();
        test_illegal();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
